// File: rtl/fifo.sv
// First-word fall-through FIFO, depth 2**W words of B bits, async active-high reset.
// Optional occupancy output `count` is enabled by defining FIFO_COUNT_EN.
module fifo #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  output logic         full,
  output logic         empty,
  output logic [B-1:0] r_data
`ifdef FIFO_COUNT_EN
  ,
  output logic [W:0]   count
`endif
);

  logic [B-1:0] storage [2**W];
  logic [W-1:0] wr_ptr;
  logic [W-1:0] rd_ptr;
  logic [W-1:0] wr_ptr_nxt;
  logic [W-1:0] rd_ptr_nxt;
  logic         wr_ok;
  logic         rd_ok;

  // A write into a full FIFO is allowed only when a pop frees the head slot on the same edge.
  assign wr_ok      = wr & (~full | rd);
  assign rd_ok      = rd & ~empty;
  assign wr_ptr_nxt = wr_ptr + 1'b1;
  assign rd_ptr_nxt = rd_ptr + 1'b1;
  assign r_data     = storage[rd_ptr];

  // Storage has no reset; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (wr_ok) storage[wr_ptr] <= w_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr_nxt;
      if (rd_ok) rd_ptr <= rd_ptr_nxt;
      case ({wr_ok, rd_ok})
        2'b10: begin
          empty <= 1'b0;
          full  <= (wr_ptr_nxt == rd_ptr);
        end
        2'b01: begin
          full  <= 1'b0;
          empty <= (rd_ptr_nxt == wr_ptr);
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo (B=8, W=4); checks count when FIFO_COUNT_EN is defined.
module tb_fifo;
  logic       clk = 1'b0;
  logic       reset;
  logic       rd;
  logic       wr;
  logic [7:0] w_data;
  logic       full;
  logic       empty;
  logic [7:0] r_data;
`ifdef FIFO_COUNT_EN
  logic [4:0] count;
`endif

  int tests_run = 0;
  int failures  = 0;

  fifo #(.B(8), .W(4)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .w_data(w_data),
    .full(full), .empty(empty), .r_data(r_data)
`ifdef FIFO_COUNT_EN
    , .count(count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; rd = 1'b0; wr = 1'b0; w_data = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    wr = 1'b1; w_data = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    tests_run++;
    if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got %b want 1", empty); end
    tests_run++;
    if (full !== 1'b0) begin failures++; $display("FAIL reset_full got %b want 0", full); end
`ifdef FIFO_COUNT_EN
    tests_run++;
    if (count !== 5'd0) begin failures++; $display("FAIL reset_count got %0d want 0", count); end
`endif
  endtask

  task automatic test_basic;
    logic [7:0] exp_head [3] = '{8'd20, 8'd30, 8'd0};
    do_reset();
    push(8'd10); push(8'd20); push(8'd30);
    tests_run++;
    if (empty !== 1'b0 || full !== 1'b0 || r_data !== 8'd10) begin
      failures++;
      $display("FAIL basic_after_writes got e=%b f=%b d=%0d want e=0 f=0 d=10", empty, full, r_data);
    end
    for (int i = 0; i < 3; i++) begin
      rd = 1'b1;
      tick();
      rd = 1'b0;
      tests_run++;
      if (i < 2 && (r_data !== exp_head[i] || empty !== 1'b0)) begin
        failures++;
        $display("FAIL basic_pop%0d got d=%0d e=%b want d=%0d e=0", i, r_data, empty, exp_head[i]);
      end else if (i == 2 && empty !== 1'b1) begin
        failures++;
        $display("FAIL basic_pop_last got e=%b want 1", empty);
      end
    end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tests_run++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL basic_read_empty got e=%b f=%b want e=1 f=0", empty, full);
    end
    // A pointer that moved on the empty read would leave the head off the new word.
    push(8'd55);
    tests_run++;
    if (r_data !== 8'd55 || empty !== 1'b0) begin
      failures++;
      $display("FAIL basic_after_empty_read got d=%0d e=%b want d=55 e=0", r_data, empty);
    end
  endtask

  task automatic test_full;
    do_reset();
    for (int i = 0; i < 15; i++) push(8'(i));
    tests_run++;
    if (full !== 1'b0) begin failures++; $display("FAIL full_at_15 got %b want 0", full); end
    push(8'd15);
    tests_run++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      failures++;
      $display("FAIL full_at_16 got f=%b e=%b want f=1 e=0", full, empty);
    end
`ifdef FIFO_COUNT_EN
    tests_run++;
    if (count !== 5'd16) begin failures++; $display("FAIL full_count got %0d want 16", count); end
`endif
    push(8'd99);
    tests_run++;
    if (full !== 1'b1 || r_data !== 8'd0) begin
      failures++;
      $display("FAIL full_ignored_write got f=%b d=%0d want f=1 d=0", full, r_data);
    end
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (r_data !== 8'(i)) begin
        failures++;
        $display("FAIL full_drain%0d got %0d want %0d", i, r_data, i);
      end
      rd = 1'b1;
      tick();
      rd = 1'b0;
    end
    tests_run++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL full_drained got e=%b f=%b want e=1 f=0", empty, full);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int i = 0; i < 5; i++) push(8'(100 + i));
    rd = 1'b1; wr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tests_run++;
      if (r_data !== 8'(100 + i) || empty !== 1'b0 || full !== 1'b0) begin
        failures++;
        $display("FAIL b2b_cycle%0d got d=%0d e=%b f=%b want d=%0d e=0 f=0",
                 i, r_data, empty, full, 100 + i);
      end
`ifdef FIFO_COUNT_EN
      tests_run++;
      if (count !== 5'd5) begin failures++; $display("FAIL b2b_count%0d got %0d want 5", i, count); end
`endif
      w_data = 8'(105 + i);
      tick();
    end
    rd = 1'b0; wr = 1'b0;
    tests_run++;
    if (r_data !== 8'd120) begin failures++; $display("FAIL b2b_final got %0d want 120", r_data); end
  endtask

  task automatic test_rw_edges;
    do_reset();
    rd = 1'b1; wr = 1'b1; w_data = 8'd7;
    tick();
    rd = 1'b0; wr = 1'b0;
    tests_run++;
    if (empty !== 1'b0 || r_data !== 8'd7) begin
      failures++;
      $display("FAIL rw_empty got e=%b d=%0d want e=0 d=7", empty, r_data);
    end
    for (int i = 8; i < 23; i++) push(8'(i));
    tests_run++;
    if (full !== 1'b1) begin failures++; $display("FAIL rw_fill got f=%b want 1", full); end
    rd = 1'b1; wr = 1'b1; w_data = 8'd200;
    tick();
    rd = 1'b0; wr = 1'b0;
    tests_run++;
    if (full !== 1'b1 || r_data !== 8'd8) begin
      failures++;
      $display("FAIL rw_full got f=%b d=%0d want f=1 d=8", full, r_data);
    end
`ifdef FIFO_COUNT_EN
    tests_run++;
    if (count !== 5'd16) begin failures++; $display("FAIL rw_full_count got %0d want 16", count); end
`endif
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (r_data !== ((i < 15) ? 8'(8 + i) : 8'd200)) begin
        failures++;
        $display("FAIL rw_drain%0d got %0d want %0d", i, r_data, (i < 15) ? 8 + i : 200);
      end
      rd = 1'b1;
      tick();
      rd = 1'b0;
    end
    tests_run++;
    if (empty !== 1'b1) begin failures++; $display("FAIL rw_drained got e=%b want 1", empty); end
  endtask

  task automatic test_async_reset;
    do_reset();
    push(8'd1); push(8'd2); push(8'd3);
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got e=%b f=%b want e=1 f=0", empty, full);
    end
`ifdef FIFO_COUNT_EN
    tests_run++;
    if (count !== 5'd0) begin failures++; $display("FAIL async_reset_count got %0d want 0", count); end
`endif
    #1;
    reset = 1'b0;
    push(8'd42);
    tests_run++;
    if (r_data !== 8'd42 || empty !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_write got d=%0d e=%b want d=42 e=0", r_data, empty);
    end
  endtask

  initial begin
    reset = 1'b1; rd = 1'b0; wr = 1'b0; w_data = '0;
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_rw_edges();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule
